// File: rtl/fir_output_quantizer.sv
// fir_output_quantizer
//   Output stage of the parallel FIR adder tree. Rounds the raw signed filter
//   sum (half toward +inf), right-shifts it by the coefficient scale, saturates
//   it to OUT_W bits, keeps one sample in every DECIM, and buffers kept samples
//   in a show-ahead FIFO so a stalling consumer does not stall the filter.
// Ports
//   clk, reset     rising-edge clock, synchronous active-high reset
//   in_valid       in_data carries a new filter sample this cycle
//   in_data        signed filter sum (IN_W bits)
//   out_valid      FIFO not empty
//   out_ready      consumer takes out_data this cycle
//   out_data       head-of-FIFO sample, 0 while empty
//   fifo_count     FIFO occupancy
//   sat_flag       sticky: a kept sample was clipped
//   ovf_flag       sticky: a kept sample was dropped on a full FIFO
//   clear_flags    clears both sticky flags (a same-cycle set wins)
module fir_output_quantizer #(
  parameter int IN_W       = 32,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 15,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [IN_W-1:0]               in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_W-1:0]              out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          sat_flag,
  output logic                          ovf_flag,
  input  logic                          clear_flags
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [IN_W:0] RND = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);

  // Quantizer (combinational)
  logic signed [IN_W:0]  q_ext;
  logic signed [IN_W:0]  q_rnd;
  logic signed [IN_W:0]  q_shr;
  logic [IN_W:OUT_W-1]   q_hi;
  logic                  q_clip;
  logic [OUT_W-1:0]      q_sat;

  always_comb begin
    // One extra sign bit so +max plus the rounding constant cannot wrap.
    q_ext  = {in_data[IN_W-1], in_data};
    q_rnd  = q_ext + RND;
    q_shr  = q_rnd >>> SHIFT;
    // In range iff every bit above the output sign bit matches it.
    q_hi   = q_shr[IN_W:OUT_W-1];
    q_clip = !((&q_hi) || (~|q_hi));
    q_sat  = q_clip ? {q_shr[IN_W], {(OUT_W-1){~q_shr[IN_W]}}} : q_shr[OUT_W-1:0];
  end

  // State
  logic [PW-1:0]    phase_q, phase_d;
  logic             s1_valid_q, s1_valid_d;
  logic [OUT_W-1:0] s1_data_q, s1_data_d;
  logic             s1_sat_q, s1_sat_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             sat_q, sat_d;
  logic             ovf_q, ovf_d;
  logic [OUT_W-1:0] mem_q [FIFO_DEPTH];

  logic keep;
  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic wr_en;
  logic drop;

  always_comb begin
    keep       = in_valid && (phase_q == '0);
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CW'(FIFO_DEPTH));
    pop        = !fifo_empty && out_ready;
    // A full FIFO still accepts the write when the head leaves in the same cycle.
    wr_en      = s1_valid_q && (!fifo_full || pop);
    drop       = s1_valid_q && fifo_full && !pop;

    phase_d = phase_q;
    if (in_valid) begin
      phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + PW'(1);
    end

    s1_valid_d = keep;
    s1_data_d  = keep ? q_sat : s1_data_q;
    s1_sat_d   = keep && q_clip;

    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(wr_en) - CW'(pop);

    sat_d = (clear_flags ? 1'b0 : sat_q) | (s1_valid_q && s1_sat_q);
    ovf_d = (clear_flags ? 1'b0 : ovf_q) | drop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_sat_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sat_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_sat_q   <= s1_sat_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sat_q      <= sat_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage is not reset; out_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= s1_data_q;
    end
  end

  always_comb begin
    out_valid  = !fifo_empty;
    out_data   = fifo_empty ? '0 : mem_q[rd_ptr_q];
    fifo_count = count_q;
    sat_flag   = sat_q;
    ovf_flag   = ovf_q;
  end

endmodule

// File: tb/tb_fir_output_quantizer.sv
// Testbench for fir_output_quantizer: two instances (DECIM=1 and DECIM=4)
// share the input stream; both are compared every cycle against a
// transaction-level reference model, with directed checks for the key cases.
module tb_fir_output_quantizer;

  localparam int  OW = 16;
  localparam int  SH = 15;
  localparam int  FD = 8;
  localparam int  CW = 4;
  localparam longint MAXV = (longint'(1) << (OW - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (OW - 1));

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        clear_flags = 1'b0;
  logic        rdy1 = 1'b1;
  logic        rdy4 = 1'b1;
  logic [31:0] in_data = '0;

  logic          ov1, ov4, sf1, sf4, of1, of4;
  logic [15:0]   od1, od4;
  logic [CW-1:0] fc1, fc4;

  int n_assert = 0;
  int n_fail   = 0;

  fir_output_quantizer #(.IN_W(32), .OUT_W(OW), .SHIFT(SH), .DECIM(1), .FIFO_DEPTH(FD)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov1), .out_ready(rdy1), .out_data(od1), .fifo_count(fc1),
    .sat_flag(sf1), .ovf_flag(of1), .clear_flags(clear_flags));

  fir_output_quantizer #(.IN_W(32), .OUT_W(OW), .SHIFT(SH), .DECIM(4), .FIFO_DEPTH(FD)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov4), .out_ready(rdy4), .out_data(od4), .fifo_count(fc4),
    .sat_flag(sf4), .ovf_flag(of4), .clear_flags(clear_flags));

  always #5 clk = ~clk;

  // Reference model state, index 0 = DECIM 1, index 1 = DECIM 4
  int          dec [2] = '{1, 4};
  logic [15:0] mbuf [2][FD];
  int          mcnt [2];
  bit          ms1v [2];
  logic [15:0] ms1d [2];
  bit          ms1s [2];
  int          mseen [2];
  bit          msat [2];
  bit          movf [2];

  logic [15:0] cap1 [$];
  logic [15:0] cap4 [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // round(x / 2^SH) with halves toward +inf, then clamp
  function automatic void quant(input logic [31:0] d, output logic [15:0] o, output bit clip);
    longint v, t, r, den;
    den = longint'(1) << SH;
    v = longint'($signed(d));
    t = v + (den / 2);
    if (t >= 0) r = t / den;
    else        r = -((-t + den - 1) / den);
    clip = 1'b0;
    if (r > MAXV) begin r = MAXV; clip = 1'b1; end
    else if (r < MINV) begin r = MINV; clip = 1'b1; end
    o = r[15:0];
  endfunction

  task automatic model_step(input int i, input bit rdy);
    bit          pop;
    logic [15:0] qd;
    bit          qc;
    if (reset) begin
      mcnt[i] = 0; ms1v[i] = 0; mseen[i] = 0; msat[i] = 0; movf[i] = 0;
      return;
    end
    pop = (mcnt[i] > 0) && rdy;
    if (clear_flags) begin msat[i] = 0; movf[i] = 0; end
    if (pop) begin
      for (int k = 0; k < FD - 1; k++) mbuf[i][k] = mbuf[i][k+1];
      mcnt[i]--;
    end
    if (ms1v[i]) begin
      if (ms1s[i]) msat[i] = 1;
      if (mcnt[i] < FD) begin
        mbuf[i][mcnt[i]] = ms1d[i];
        mcnt[i]++;
      end else begin
        movf[i] = 1;
      end
    end
    quant(in_data, qd, qc);
    ms1v[i] = in_valid && ((mseen[i] % dec[i]) == 0);
    ms1d[i] = qd;
    ms1s[i] = qc;
    if (in_valid) mseen[i]++;
  endtask

  task automatic check_dut(input int i, input logic v, input logic [15:0] d,
                           input logic [CW-1:0] c, input logic s, input logic o);
    string sfx;
    sfx = $sformatf("_d%0d", dec[i]);
    chk({"out_valid", sfx}, 32'(v), 32'(mcnt[i] > 0));
    chk({"out_data", sfx}, 32'(d), (mcnt[i] > 0) ? 32'(mbuf[i][0]) : 32'd0);
    chk({"fifo_count", sfx}, 32'(c), 32'(mcnt[i]));
    chk({"sat_flag", sfx}, 32'(s), 32'(msat[i]));
    chk({"ovf_flag", sfx}, 32'(o), 32'(movf[i]));
  endtask

  // One clock: record what the consumers take, advance model, compare.
  task automatic cycle();
    if (ov1 === 1'b1 && rdy1) cap1.push_back(od1);
    if (ov4 === 1'b1 && rdy4) cap4.push_back(od4);
    @(posedge clk);
    model_step(0, rdy1);
    model_step(1, rdy4);
    #1;
    check_dut(0, ov1, od1, fc1, sf1, of1);
    check_dut(1, ov4, od4, fc4, sf4, of4);
  endtask

  task automatic put(input bit v, input logic [31:0] d);
    in_valid = v;
    in_data  = d;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) put(1'b0, 32'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
  endtask

  logic [31:0] rin  [4] = '{32'h0000_4000, 32'h0000_3FFF, 32'hFFFF_C000, 32'hFFFF_BFFF};
  logic [15:0] rexp [4] = '{16'h0001, 16'h0000, 16'h0000, 16'hFFFF};

  initial begin
    logic [31:0] d;
    int          k;
    int          c;

    // Reset state
    reset = 1'b1;
    idle(2);
    chk("reset_count", 32'(fc1), 32'd0);
    chk("reset_valid", 32'(ov4), 32'd0);
    reset = 1'b0;

    // Rounding
    for (int j = 0; j < 4; j++) begin
      put(1'b1, rin[j]);
      put(1'b0, 32'd0);
      chk($sformatf("round_%0d", j), 32'(od1), 32'(rexp[j]));
    end
    chk("round_no_sat", 32'(sf1), 32'd0);

    // Saturation
    put(1'b1, 32'h7FFF_FFFF);
    put(1'b0, 32'd0);
    chk("sat_pos_data", 32'(od1), 32'h7FFF);
    chk("sat_pos_flag", 32'(sf1), 32'd1);
    clear_flags = 1'b1;
    put(1'b0, 32'd0);
    clear_flags = 1'b0;
    chk("sat_cleared", 32'(sf1), 32'd0);
    put(1'b1, 32'h8000_0000);
    put(1'b0, 32'd0);
    chk("sat_neg_data", 32'(od1), 32'h8000);
    chk("sat_neg_flag", 32'(sf1), 32'd1);
    idle(2);

    // Decimation by 4, in_valid low every third cycle
    pulse_reset();
    cap4.delete();
    put(1'b1, 32'd0);
    chk("dec_lat1", 32'(ov4), 32'd0);
    put(1'b1, 32'h8000);
    chk("dec_lat2", 32'(ov4), 32'd1);
    chk("dec_lat2_data", 32'(od4), 32'd0);
    k = 2;
    c = 2;
    while (k < 12) begin
      if (c % 3 == 2) put(1'b0, 32'd0);
      else begin
        put(1'b1, 32'(k) * 32'h8000);
        k++;
      end
      c++;
    end
    idle(4);
    chk("dec_count", 32'(cap4.size()), 32'd3);
    for (int j = 0; j < 3 && j < cap4.size(); j++)
      chk($sformatf("dec_out_%0d", j), 32'(cap4[j]), 32'(4 * j));

    // Backpressure and overflow
    pulse_reset();
    rdy1 = 1'b0;
    for (int j = 1; j <= 10; j++) put(1'b1, 32'(j) << 15);
    idle(2);
    chk("bp_count", 32'(fc1), 32'd8);
    chk("bp_ovf", 32'(of1), 32'd1);
    cap1.delete();
    rdy1 = 1'b1;
    idle(10);
    chk("bp_drained", 32'(cap1.size()), 32'd8);
    for (int j = 0; j < 8 && j < cap1.size(); j++)
      chk($sformatf("bp_out_%0d", j), 32'(cap1[j]), 32'(j + 1));
    chk("bp_empty", 32'(ov1), 32'd0);

    // Full FIFO with simultaneous write and pop
    pulse_reset();
    rdy1 = 1'b0;
    for (int j = 1; j <= 8; j++) put(1'b1, 32'(j) << 15);
    idle(2);
    chk("full_count", 32'(fc1), 32'd8);
    cap1.delete();
    put(1'b1, 32'd100 << 15);
    rdy1 = 1'b1;
    for (int j = 101; j < 120; j++) begin
      put(1'b1, 32'(j) << 15);
      chk($sformatf("full_hold_%0d", j), 32'(fc1), 32'd8);
    end
    idle(12);
    chk("full_no_ovf", 32'(of1), 32'd0);
    chk("full_total", 32'(cap1.size()), 32'd28);
    for (int j = 0; j < 28 && j < cap1.size(); j++)
      chk($sformatf("full_out_%0d", j), 32'(cap1[j]), (j < 8) ? 32'(j + 1) : 32'(92 + j));

    // Reset mid-run
    pulse_reset();
    rdy1 = 1'b0;
    put(1'b1, 32'h7FFF_FFFF);
    for (int j = 2; j <= 6; j++) put(1'b1, 32'(j) << 15);
    in_valid = 1'b0;
    chk("mid_count", 32'(fc1), 32'd5);
    chk("mid_sat", 32'(sf1), 32'd1);
    pulse_reset();
    chk("rst_valid", 32'(ov1), 32'd0);
    chk("rst_count", 32'(fc1), 32'd0);
    chk("rst_sat", 32'(sf1), 32'd0);
    chk("rst_ovf", 32'(of1), 32'd0);
    rdy1 = 1'b1;
    put(1'b1, 32'd3 << 15);
    put(1'b0, 32'd0);
    chk("rst_keep_valid", 32'(ov4), 32'd1);
    chk("rst_keep_data", 32'(od4), 32'd3);
    idle(3);

    // Random traffic against the model
    for (int n = 0; n < 500; n++) begin
      reset       = ($urandom_range(0, 149) == 0);
      clear_flags = ($urandom_range(0, 15) == 0);
      rdy1        = ($urandom_range(0, 3) != 0);
      rdy4        = ($urandom_range(0, 2) != 0);
      d = $urandom;
      case ($urandom_range(0, 3))
        0: d = {{11{d[20]}}, d[20:0]};
        1: d = d;
        2: d = d[0] ? 32'h7FFF_FFFF : 32'h8000_0000;
        default: d = {{16{d[15]}}, d[15:0]};
      endcase
      put($urandom_range(0, 4) != 0, d);
    end
    reset = 1'b0;
    clear_flags = 1'b0;
    rdy1 = 1'b1;
    rdy4 = 1'b1;
    idle(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
